// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register block in front of custom_axi_ip: drives the core's input
// data and start pulse, captures its result and status for software polling.
module custom_axi_ip_regs #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // AXI4-Lite write address
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // AXI4-Lite write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // AXI4-Lite write response
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // AXI4-Lite read address
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // AXI4-Lite read data
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // Core side
  output logic [DATA_WIDTH-1:0]   ipreg_data_o,
  output logic                    enable_o,
  input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
  input  logic                    hw_wen_i,
  input  logic [1:0]              status_i
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [1:0] AddrCtrl    = 2'd0;
  localparam logic [1:0] AddrDataIn  = 2'd1;
  localparam logic [1:0] AddrDataOut = 2'd2;
  localparam logic [1:0] AddrStatus  = 2'd3;

  localparam logic [1:0] StatusIdle = 2'd0;

  // Write holding buffers
  logic                  aw_full_q;
  logic [1:0]            aw_addr_q;
  logic                  w_full_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [StrbWidth-1:0]  w_strb_q;

  // Response channels
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  // Register state
  logic [DATA_WIDTH-1:0] data_in_q;
  logic [DATA_WIDTH-1:0] data_in_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  done_q;
  logic                  drop_q;
  logic                  enable_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  start_req;
  logic                  start_ok;
  logic                  start_drop;
  logic                  done_clr;
  logic                  drop_clr;
  logic [DATA_WIDTH-1:0] rd_mux;

  // Low address bits are ignored and high bits alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = !aw_full_q && !rst_i;
  assign s_axi_wready  = !w_full_q && !rst_i;
  assign s_axi_arready = !rvalid_q && !rst_i;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ipreg_data_o  = data_in_q;
  assign enable_o      = enable_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Commit decode and byte-strobed DATA_IN next value
  always_comb begin
    commit     = aw_full_q && w_full_q && !bvalid_q;
    start_req  = commit && (aw_addr_q == AddrCtrl) && w_strb_q[0] && w_data_q[0];
    start_ok   = start_req && (status_i == StatusIdle);
    start_drop = start_req && (status_i != StatusIdle);
    done_clr   = commit && (aw_addr_q == AddrStatus) && w_data_q[8];
    drop_clr   = commit && (aw_addr_q == AddrStatus) && w_data_q[9];
    data_in_d  = data_in_q;
    for (int i = 0; i < StrbWidth; i++) begin
      if (w_strb_q[i]) begin
        data_in_d[8*i +: 8] = w_data_q[8*i +: 8];
      end
    end
  end

  // Read data selection from current register state
  always_comb begin
    rd_mux = '0;
    unique case (s_axi_araddr[3:2])
      AddrCtrl:    rd_mux = '0;
      AddrDataIn:  rd_mux = data_in_q;
      AddrDataOut: rd_mux = data_out_q;
      AddrStatus:  rd_mux = {{(DATA_WIDTH-10){1'b0}}, drop_q, done_q, 6'b0, status_i};
      default:     rd_mux = '0;
    endcase
  end

  // AW holding buffer; cleared on commit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
    end else if (commit) begin
      aw_full_q <= 1'b0;
    end else if (aw_hs) begin
      aw_full_q <= 1'b1;
      aw_addr_q <= s_axi_awaddr[3:2];
    end
  end

  // W holding buffer; cleared on commit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_full_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      w_full_q <= 1'b0;
    end else if (w_hs) begin
      w_full_q <= 1'b1;
      w_data_q <= s_axi_wdata;
      w_strb_q <= s_axi_wstrb;
    end
  end

  // Write response: raised on commit, held until bready
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RespOkay;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= (aw_addr_q == AddrDataOut) ? RespSlvErr : RespOkay;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read response: sampled on AR handshake, held until rready
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
      rresp_q  <= RespOkay;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // DATA_IN register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_in_q <= '0;
    end else if (commit && (aw_addr_q == AddrDataIn)) begin
      data_in_q <= data_in_d;
    end
  end

  // Core result capture and sticky flags; a hardware set beats a W1C
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_out_q <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      if (hw_wen_i) begin
        data_out_q <= ipreg_data_i;
      end
      if (hw_wen_i) begin
        done_q <= 1'b1;
      end else if (done_clr) begin
        done_q <= 1'b0;
      end
      if (start_drop) begin
        drop_q <= 1'b1;
      end else if (drop_clr) begin
        drop_q <= 1'b0;
      end
    end
  end

  // One-cycle start pulse, only when the core is idle at commit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= start_ok;
    end
  end

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// Self-checking bench for custom_axi_ip_regs: transaction-level register model
// plus a per-cycle compare of the core-facing outputs.
module tb_custom_axi_ip_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] ipreg_data_o;
  logic        enable_o;
  logic [31:0] core_data = '0;
  logic        hw_wen = 1'b0;
  logic [1:0]  status = 2'd0;

  always #5 clk = ~clk;

  custom_axi_ip_regs #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .ipreg_data_o (ipreg_data_o),
    .enable_o     (enable_o),
    .ipreg_data_i (core_data),
    .hw_wen_i     (hw_wen),
    .status_i     (status)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_count = 0;
  always @(negedge clk) if (enable_o) en_count <= en_count + 1;

  // Register model
  logic [31:0] m_data_in  = '0;
  logic [31:0] m_data_out = '0;
  logic        m_done     = 1'b0;
  logic        m_drop     = 1'b0;
  int          m_pulse_cyc = -10;
  bit          chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data_in   = '0;
    m_data_out  = '0;
    m_done      = 1'b0;
    m_drop      = 1'b0;
    m_pulse_cyc = -10;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return 32'h0;
      2'd1:    return m_data_in;
      2'd2:    return m_data_out;
      default: return {22'h0, m_drop, m_done, 6'h0, status};
    endcase
  endfunction

  // Apply a committed write to the model; called right after the commit edge.
  task automatic model_commit(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] eresp);
    eresp = 2'b00;
    case (a[3:2])
      2'd0: if (s[0] && d[0]) begin
        if (status == 2'd0) m_pulse_cyc = cyc;
        else m_drop = 1'b1;
      end
      2'd1: for (int k = 0; k < 4; k++) if (s[k]) m_data_in[8*k +: 8] = d[8*k +: 8];
      2'd2: eresp = 2'b10;
      default: begin
        if (d[8]) m_done = 1'b0;
        if (d[9]) m_drop = 1'b0;
      end
    endcase
  endtask

  // Per-cycle compare of core-facing outputs
  always @(negedge clk) begin
    if (chk_en) begin
      check("ipreg_data_o", ipreg_data_o, m_data_in);
      check("enable_o", 32'(enable_o), 32'(cyc == m_pulse_cyc));
    end
  end

  task automatic apply_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("awready in reset", 32'(awready), 32'h0);
    check("wready in reset", 32'(wready), 32'h0);
    check("arready in reset", 32'(arready), 32'h0);
    check("bvalid after reset", 32'(bvalid), 32'h0);
    check("rvalid after reset", 32'(rvalid), 32'h0);
    check("rdata after reset", rdata, 32'h0);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
  endtask

  // AW+W together; optional hw_wen on the expected commit edge.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit hw, input logic [31:0] hw_d, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, ha, hwd;
    int t = 0;
    logic [1:0] eresp;
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    bready = 1'b1;
    while (!(aw_done && w_done) && t < 20) begin
      @(negedge clk);
      ha  = awvalid && awready;
      hwd = wvalid && wready;
      @(posedge clk); #1;
      if (ha) begin awvalid = 1'b0; aw_done = 1; end
      if (hwd) begin wvalid = 1'b0; w_done = 1; end
      t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write handshake", {30'h0, aw_done, w_done}, 32'h3);
      resp = 2'b11;
      return;
    end
    if (hw) begin hw_wen = 1'b1; core_data = hw_d; end
    @(posedge clk); #1;
    hw_wen = 1'b0;
    t = 1;
    while (!bvalid && t < 20) begin @(posedge clk); #1; t++; end
    check("commit latency", t, 1);
    model_commit(a, d, s, eresp);
    if (hw) begin m_data_out = hw_d; m_done = 1'b1; end
    resp = bresp;
    check("bresp", 32'(bresp), 32'(eresp));
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid after B handshake", 32'(bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    bit hs = 0;
    int t = 0;
    logic [31:0] exp;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    exp = '0;
    while (!hs && t < 20) begin
      @(negedge clk);
      hs  = arready;
      exp = model_read(a);
      @(posedge clk); #1;
      t++;
    end
    arvalid = 1'b0;
    check("ar handshake", 32'(hs), 32'h1);
    check("rvalid", 32'(rvalid), 32'h1);
    check("rdata", rdata, exp);
    check("rresp", 32'(rresp), 32'h0);
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid after R handshake", 32'(rvalid), 32'h0);
  endtask

  task automatic hw_pulse(input logic [31:0] d);
    @(negedge clk);
    hw_wen = 1'b1; core_data = d;
    @(posedge clk); #1;
    hw_wen = 1'b0;
    m_data_out = d;
    m_done = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    logic [1:0]  eresp;
    int          en0;

    // Reset and read back all four registers
    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    check("enable_o reset", 32'(enable_o), 32'h0);
    check("ipreg_data_o reset", ipreg_data_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check("reset readback", rd, 32'h0);
    end

    // Byte-strobed DATA_IN
    axi_write(4'h4, 32'hA5A5_0001, 4'hF, 0, 32'h0, rsp);
    axi_write(4'h4, 32'hFFFF_FFFF, 4'h2, 0, 32'h0, rsp);
    check("data_in strobed", ipreg_data_o, 32'hA5A5_FF01);
    axi_read(4'h4, rd);
    check("data_in readback", rd, 32'hA5A5_FF01);

    // W three cycles before AW, bready low for four cycles
    @(negedge clk);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    awaddr = 4'h4; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("bvalid before commit", 32'(bvalid), 32'h0);
    @(posedge clk); #1;
    check("bvalid at commit", 32'(bvalid), 32'h1);
    model_commit(4'h4, 32'h1234_5678, 4'hF, eresp);
    check("bresp W-first", 32'(bresp), 32'(eresp));
    awaddr = 4'h4; awvalid = 1'b1;
    wdata = 32'hCAFE_0000; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check("bvalid held", 32'(bvalid), 32'h1);
      check("awready while buffered", 32'(awready), 32'h0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    check("bvalid after first B", 32'(bvalid), 32'h0);
    @(posedge clk); #1;
    check("second commit", 32'(bvalid), 32'h1);
    model_commit(4'h4, 32'hCAFE_0000, 4'hF, eresp);
    @(posedge clk); #1;
    bready = 1'b0;
    check("ipreg after second", ipreg_data_o, 32'hCAFE_0000);

    // START while idle, then result capture and DONE W1C
    status = 2'd0;
    en0 = en_count;
    axi_write(4'h0, 32'h1, 4'h1, 0, 32'h0, rsp);
    @(negedge clk);
    check("start pulse count", en_count - en0, 1);
    hw_pulse(32'h0000_1235);
    axi_read(4'h8, rd);
    check("data_out", rd, 32'h0000_1235);
    axi_read(4'hC, rd);
    check("status done", rd, 32'h0000_0100);
    axi_write(4'hC, 32'h100, 4'hF, 0, 32'h0, rsp);
    axi_read(4'hC, rd);
    check("status done cleared", rd, 32'h0);

    // START while busy sets DROP; W1C of DONE loses to hw_wen
    status = 2'd1;
    en0 = en_count;
    axi_write(4'h0, 32'h1, 4'hF, 0, 32'h0, rsp);
    check("bresp dropped start", 32'(rsp), 32'h0);
    repeat (2) @(negedge clk);
    check("no start pulse", en_count - en0, 0);
    axi_read(4'hC, rd);
    check("status drop", rd & 32'h3FF, 32'h201);
    axi_write(4'hC, 32'h100, 4'hF, 1, 32'h0000_0055, rsp);
    axi_read(4'hC, rd);
    check("done set wins", rd, 32'h301);
    axi_write(4'hC, 32'h200, 4'h0, 0, 32'h0, rsp);
    axi_read(4'hC, rd);
    check("drop cleared", rd, 32'h101);

    // DATA_OUT is read-only
    axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, rsp);
    check("slverr", 32'(rsp), 32'h2);
    axi_read(4'h8, rd);
    check("data_out unchanged", rd, 32'h55);

    // Reset while a read response waits for rready
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid pending", 32'(rvalid), 32'h1);
    @(posedge clk); #1;
    check("rvalid held", 32'(rvalid), 32'h1);
    check("rdata held", rdata, 32'hCAFE_0000);
    apply_reset();
    check("ipreg after reset", ipreg_data_o, 32'h0);
    check("enable after reset", 32'(enable_o), 32'h0);
    axi_read(4'h4, rd);
    check("data_in cleared", rd, 32'h0);
    axi_read(4'hC, rd);
    check("status cleared", rd, 32'h1);
    axi_read(4'h8, rd);
    check("data_out cleared", rd, 32'h0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
